// File: rtl/cpu.sv
// Reciprocal engine: reads a 16-bit divisor from DM1, writes floor(2^15/divisor) back, raises Ack.
// Optional build macro RECIP_ROUND_EN selects half-LSB upward rounding instead of truncation.

module cpu_dmem #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_hi,
    input  logic [AW-1:0] raddr_lo,
    output logic [7:0]    rdata_hi,
    output logic [7:0]    rdata_lo
);
    logic [7:0] Core [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) Core[waddr] <= wdata;
    end

    assign rdata_hi = Core[raddr_hi];
    assign rdata_lo = Core[raddr_lo];
endmodule

module cpu #(
    parameter int MEM_DEPTH = 256,
    parameter int DIV_ADDR  = 8,
    parameter int RES_ADDR  = 10
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] DIV_HI = AW'(DIV_ADDR);
    localparam logic [AW-1:0] DIV_LO = AW'(DIV_ADDR + 1);
    localparam logic [AW-1:0] RES_HI = AW'(RES_ADDR);
    localparam logic [AW-1:0] RES_LO = AW'(RES_ADDR + 1);
`ifdef RECIP_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ARMED, LOAD, DIV, STORE_HI, STORE_LO, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] divisor_q, divisor_d;
    logic [15:0] rem_q, rem_d;
    logic [16:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        ack_q, ack_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    rd_hi, rd_lo;
    logic [16:0]   trial, diff;
    logic          q_bit;

    cpu_dmem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) DM1 (
        .clk      (Clk),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    (mem_wdata),
        .raddr_hi (DIV_HI),
        .raddr_lo (DIV_LO),
        .rdata_hi (rd_hi),
        .rdata_lo (rd_lo)
    );

    // q = floor(2^16/d); the reported result drops the extra fraction bit, optionally rounding on it
    function automatic logic [15:0] recip_result(input logic [16:0] q);
        logic [16:0] sum;
        sum = {1'b0, q[16:1]} + 17'(q[0] & ROUND_EN);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Restoring step: the dividend bits stream out of the top of quo while quotient bits enter at the bottom
    assign trial = {rem_q, quo_q[16]};
    assign diff  = trial - {1'b0, divisor_q};
    assign q_bit = (trial >= {1'b0, divisor_q});

    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ack_d     = ack_q;
        mem_we    = 1'b0;
        mem_waddr = RES_HI;
        mem_wdata = result_q[15:8];
        case (state_q)
            IDLE:  if (Start) state_d = ARMED;
            ARMED: if (!Start) state_d = LOAD;
            LOAD: begin
                divisor_d = {rd_hi, rd_lo};
                rem_d     = 16'h0000;
                quo_d     = 17'h10000;
                cnt_d     = 5'd0;
                if ({rd_hi, rd_lo} == 16'h0000) begin
                    result_d = 16'hFFFF;
                    state_d  = STORE_HI;
                end else begin
                    state_d  = DIV;
                end
            end
            DIV: begin
                rem_d = q_bit ? diff[15:0] : trial[15:0];
                quo_d = {quo_q[15:0], q_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd16) begin
                    result_d = recip_result({quo_q[15:0], q_bit});
                    state_d  = STORE_HI;
                end
            end
            STORE_HI: begin
                mem_we    = 1'b1;
                mem_waddr = RES_HI;
                mem_wdata = result_q[15:8];
                state_d   = STORE_LO;
            end
            STORE_LO: begin
                mem_we    = 1'b1;
                mem_waddr = RES_LO;
                mem_wdata = result_q[7:0];
                state_d   = DONE;
            end
            DONE: begin
                if (Start) begin
                    ack_d   = 1'b0;
                    state_d = ARMED;
                end else begin
                    ack_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ack_q     <= ack_d;
        end
    end

    assign Ack = ack_q;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the reciprocal engine; memory is loaded and read through DM1.Core.
module tb_cpu;
    logic Clk, Reset, Start, Ack;
    int   checks   = 0;
    int   failures = 0;
`ifdef RECIP_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    cpu dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Load divisor, pulse Start for two cycles, drop it, then count cycles to Ack.
    task automatic run(input string tag, input logic [15:0] div, input logic [15:0] exp_res,
                       input int exp_lat, input bit glitch);
        int   n;
        logic was_ack;
        was_ack = Ack;
        dut.DM1.Core[8] = div[15:8];
        dut.DM1.Core[9] = div[7:0];
        Start = 1'b1;
        tick();
        if (was_ack === 1'b1) chk({tag, "_ack_drop"}, {31'd0, Ack}, 32'd0);
        tick();
        Start = 1'b0;
        tick();
        n = 0;
        while (Ack !== 1'b1 && n < 40) begin
            if (glitch && n == 5) Start = 1'b1;
            if (glitch && n == 6) Start = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_ack"}, {31'd0, Ack}, 32'd1);
        chk({tag, "_result"}, {16'd0, dut.DM1.Core[10], dut.DM1.Core[11]}, {16'd0, exp_res});
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        dut.DM1.Core[10] = 8'hA5;
        dut.DM1.Core[11] = 8'h5A;
        tick();
        chk("reset_ack", {31'd0, Ack}, 32'd0);
        Reset = 1'b1;
        tick();
        chk("idle_ack", {31'd0, Ack}, 32'd0);

        run("div1024", 16'h0400, 16'h0020, 21, 1'b0);
        repeat (5) tick();
        chk("ack_held", {31'd0, Ack}, 32'd1);

        run("div1", 16'h0001, 16'h8000, 21, 1'b0);
        run("div3", 16'h0003, ROUND ? 16'h2AAB : 16'h2AAA, 21, 1'b1);
        run("divffff", 16'hFFFF, ROUND ? 16'h0001 : 16'h0000, 21, 1'b0);
        run("div0", 16'h0000, 16'hFFFF, 4, 1'b0);
        run("div5", 16'h0005, ROUND ? 16'h199A : 16'h1999, 21, 1'b0);
        repeat (3) tick();
        chk("div5_ack_held", {31'd0, Ack}, 32'd1);

        // Abort a run mid-division; result bytes must remain untouched.
        dut.DM1.Core[10] = 8'hA5;
        dut.DM1.Core[11] = 8'h5A;
        dut.DM1.Core[8]  = 8'h00;
        dut.DM1.Core[9]  = 8'h07;
        Start = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        repeat (8) tick();
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_ack", {31'd0, Ack}, 32'd0);
        tick();
        Reset = 1'b1;
        repeat (25) tick();
        chk("abort_idle_ack", {31'd0, Ack}, 32'd0);
        chk("abort_mem", {16'd0, dut.DM1.Core[10], dut.DM1.Core[11]}, 32'h0000A55A);

        run("div2", 16'h0002, 16'h4000, 21, 1'b0);

        // Reset asserted between clock edges must clear Ack without waiting for an edge.
        #2;
        Reset = 1'b0;
        #1;
        chk("async_ack", {31'd0, Ack}, 32'd0);
        tick();
        Reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
